// File: rtl/butterfly_pipe.sv
// butterfly_pipe: three-stage radix-2 complex butterfly (A+W*B, A-W*B) with
// round-half-up, optional halving, saturation and a sticky overflow flag.
module butterfly_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_w,
    input  logic             in_inv,
    input  logic             in_scale,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_apwb,
    output logic [WIDTH-1:0] out_anwb,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * H + 2;
    localparam int SW = H + 3;
    localparam logic signed [PW-1:0] HALF = PW'(1) <<< (H - 2);
    localparam logic signed [SW-1:0] SMAX = {4'b0000, {(H-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {4'b1111, {(H-1){1'b0}}};

    function automatic logic signed [H+1:0] rnd(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] t;
        t = (p + HALF) >>> (H - 1);
        return (H+2)'(t);
    endfunction

    // returns {saturated, value}
    function automatic logic [H:0] fin(input logic signed [SW-1:0] s, input logic sc);
        logic signed [SW-1:0] t;
        t = sc ? (s + SW'(1)) >>> 1 : s;
        return t > SMAX ? {1'b1, SMAX[H-1:0]} : t < SMIN ? {1'b1, SMIN[H-1:0]} : {1'b0, H'(t)};
    endfunction

    logic                 adv, v1_q, v2_q, v3_q, sc1_q, sc2_q, ovf_q, ovf_d;
    logic [WIDTH-1:0]     a1_q, a2_q, apwb_q, anwb_q;
    logic signed [H-1:0]  bre1_q, bim1_q, wre1_q;
    logic signed [H:0]    wim_ext, wim_d, wim1_q;
    logic signed [PW-1:0] rr_q, ii_q, ir_q, ri_q;
    logic signed [H+1:0]  wb_re, wb_im;
    logic signed [SW-1:0] a_re, a_im;
    logic [H:0]           pr, pi, nr, ni;

    always_comb begin
        adv      = ~v3_q | out_ready;
        in_ready = adv & rst_n;
        // one extra bit so that negating the most negative W_im stays exact
        wim_ext  = $signed({in_w[WIDTH-1], in_w[WIDTH-1:H]});
        wim_d    = in_inv ? -wim_ext : wim_ext;
        wb_re    = rnd(rr_q - ii_q);
        wb_im    = rnd(ir_q + ri_q);
        a_re     = SW'($signed(a2_q[H-1:0]));
        a_im     = SW'($signed(a2_q[WIDTH-1:H]));
        pr       = fin(a_re + SW'(wb_re), sc2_q);
        pi       = fin(a_im + SW'(wb_im), sc2_q);
        nr       = fin(a_re - SW'(wb_re), sc2_q);
        ni       = fin(a_im - SW'(wb_im), sc2_q);
        ovf_d    = (adv & v2_q & (pr[H] | pi[H] | nr[H] | ni[H])) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            apwb_q <= '0;
            anwb_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (adv) begin
                v1_q   <= in_valid & in_ready;
                v2_q   <= v1_q;
                v3_q   <= v2_q;
                apwb_q <= {pi[H-1:0], pr[H-1:0]};
                anwb_q <= {ni[H-1:0], nr[H-1:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            a1_q   <= in_a;
            bre1_q <= $signed(in_b[H-1:0]);
            bim1_q <= $signed(in_b[WIDTH-1:H]);
            wre1_q <= $signed(in_w[H-1:0]);
            wim1_q <= wim_d;
            sc1_q  <= in_scale;
            a2_q   <= a1_q;
            sc2_q  <= sc1_q;
            rr_q   <= PW'(wre1_q) * PW'(bre1_q);
            ii_q   <= PW'(wim1_q) * PW'(bim1_q);
            ir_q   <= PW'(wim1_q) * PW'(bre1_q);
            ri_q   <= PW'(wre1_q) * PW'(bim1_q);
        end
    end

    assign out_valid  = v3_q;
    assign out_apwb   = apwb_q;
    assign out_anwb   = anwb_q;
    assign ovf_sticky = ovf_q;
endmodule
